nmc_block_loader: RTL and testbench

- Upstream feeder for systolic_array_4x4.
- On a start pulse it fetches one 128-bit AES state and one 128-bit round key from the FeRAM read port as eight 32-bit words, and assembles them into the array's byte lanes.
- It then sequences the array: one load cycle (load_psum), then one AddRoundKey cycle.
- It is the near-memory bridge between the FeRAM macro controller and the PE grid.

---
 rtl/nmc_pkg.sv | 31 +++
 rtl/nmc_block_loader_if.sv | 13 +
 rtl/nmc_word_buf.sv | 30 +++
 rtl/nmc_block_loader.sv | 124 ++++++++++++
 tb/tb_nmc_block_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nmc_pkg.sv
// Shared types and constants for the near-memory block loader feeding the 4x4 systolic array.
package nmc_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NWORDS = 8;
  localparam int unsigned NROWS  = 4;
  localparam int unsigned WIDX_W = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BUS_W  = 128;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ARK  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ARK,
    ST_DONE
  } ld_state_e;

  // Words 0..3 are state rows, words 4..7 are key rows.
  function automatic logic is_key_word(input logic [CNT_W-1:0] w);
    return w[2];
  endfunction

  function automatic logic [1:0] row_of(input logic [CNT_W-1:0] w);
    return w[1:0];
  endfunction

endpackage

// File: rtl/nmc_block_loader_if.sv
// FeRAM read port between the block loader (master) and the memory controller (slave).
interface nmc_block_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              mem_rd_en;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (output mem_rd_en, mem_addr, input mem_ready, mem_rvalid, mem_rdata);
  modport slave  (input mem_rd_en, mem_addr, output mem_ready, mem_rvalid, mem_rdata);
endinterface

// File: rtl/nmc_word_buf.sv
// 8x32 write-indexed word buffer; exposes state rows as data_n and key rows as key.
module nmc_word_buf
  import nmc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [WIDX_W-1:0] wr_idx_i,
  input  logic [WORD_W-1:0] wr_data_i,
  output logic [BUS_W-1:0]  data_n_o,
  output logic [BUS_W-1:0]  key_o
);

  logic [WORD_W-1:0] word_q [NWORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NWORDS); i++) word_q[i] <= '0;
    end else if (wr_en_i) begin
      word_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Little-endian bytes within a word: byte 4r+c of each bus is row r, column c.
  for (genvar r = 0; r < NROWS; r++) begin : g_row
    assign data_n_o[WORD_W*r +: WORD_W] = word_q[r];
    assign key_o[WORD_W*r +: WORD_W]    = word_q[r+NROWS];
  end

endmodule

// File: rtl/nmc_block_loader.sv
// Fetches one AES state and round key from FeRAM, then sequences one load and one ARK cycle.
module nmc_block_loader
  import nmc_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  state_base,
  input  logic [ADDR_W-1:0]  key_base,
  output logic               busy,
  output logic               done,
  nmc_block_loader_if.master mem,
  output logic               pe_en,
  output logic               load_psum,
  output logic               shift_in_en,
  output logic [1:0]         op_sel,
  output logic [BUS_W-1:0]   data_n,
  output logic [BUS_W-1:0]   key
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] sbase_q, sbase_d, kbase_q, kbase_d, addr_q, addr_d;
  logic [CNT_W-1:0]  iss_q, iss_d, ret_q, ret_d;
  logic              rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d;
  logic              pe_en_q, pe_en_d, load_q, load_d;
  logic [1:0]        op_q, op_d;
  logic              wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sbase_q <= '0;
      kbase_q <= '0;
      addr_q  <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pe_en_q <= 1'b0;
      load_q  <= 1'b0;
      op_q    <= OP_PASS;
    end else begin
      state_q <= state_d;
      sbase_q <= sbase_d;
      kbase_q <= kbase_d;
      addr_q  <= addr_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pe_en_q <= pe_en_d;
      load_q  <= load_d;
      op_q    <= op_d;
    end
  end

  // Outputs are registered from the next state so the request side never sees mem_ready combinationally.
  always_comb begin
    state_d = state_q;
    sbase_d = sbase_q;
    kbase_d = kbase_q;
    iss_d   = iss_q;
    ret_d   = ret_q;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sbase_d = state_base;
          kbase_d = key_base;
          iss_d   = '0;
          ret_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (rd_en_q && mem.mem_ready) iss_d = iss_q + CNT_W'(1);
        if (mem.mem_rvalid && (ret_q < CNT_W'(NWORDS))) begin
          wr_en = 1'b1;
          ret_d = ret_q + CNT_W'(1);
        end
        if (ret_d == CNT_W'(NWORDS)) state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_ARK;
      ST_ARK:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rd_en_d = (state_d == ST_FETCH) && (iss_d < CNT_W'(NWORDS)) &&
              ((iss_d - ret_d) < CNT_W'(MAX_OUT));
    addr_d  = is_key_word(iss_d) ? (kbase_d + ADDR_W'(row_of(iss_d)))
                                 : (sbase_d + ADDR_W'(row_of(iss_d)));
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    pe_en_d = (state_d == ST_LOAD) || (state_d == ST_ARK);
    load_d  = (state_d == ST_LOAD);
    op_d    = (state_d == ST_ARK) ? OP_ARK : OP_PASS;
  end

  nmc_word_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_idx_i  (ret_q[WIDX_W-1:0]),
    .wr_data_i (mem.mem_rdata),
    .data_n_o  (data_n),
    .key_o     (key)
  );

  assign mem.mem_rd_en = rd_en_q;
  assign mem.mem_addr  = addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pe_en         = pe_en_q;
  assign load_psum     = load_q;
  assign op_sel        = op_q;
  assign shift_in_en   = 1'b0;

endmodule

// File: tb/tb_nmc_block_loader.sv
// Directed bench: instance 0 (MAX_OUT=4) and instance 1 (MAX_OUT=2) each with a fixed-latency FeRAM model.
module tb_nmc_block_loader;

  localparam int unsigned LAT = 2;
  localparam logic [127:0] EXP_DATA = 128'h00FFEEDD_CCBBAA99_88776655_44332211;
  localparam logic [127:0] EXP_KEY  = {16{8'h01}};

  logic        clk = 1'b0;
  logic [1:0]  rst_n, start, ready, inj_v;
  logic [11:0] sbase [2];
  logic [11:0] kbase [2];
  logic [31:0] inj_d;
  logic [1:0]  busy, done, pe_en, load_psum, shift_in_en, rd_w;
  logic [1:0]  op_sel [2];
  logic [11:0] addr_w [2];
  logic [127:0] data_n [2];
  logic [127:0] key [2];

  logic [31:0]    mem [4096];
  logic [LAT-1:0] pv [2];
  logic [31:0]    pd [2][LAT];
  logic [11:0]    alog [2][128];
  int aidx [2], rcnt [2], dcnt [2], lcnt [2], maxout [2], stalls [2], sviol [2];
  logic [1:0]  stall_q;
  logic [11:0] paddr_q [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    nmc_block_loader_if #(.ADDR_W(12)) mif ();
    nmc_block_loader #(.ADDR_W(12), .MAX_OUT((g == 0) ? 4 : 2)) u_dut (
      .clk(clk), .rst_n(rst_n[g]), .start(start[g]),
      .state_base(sbase[g]), .key_base(kbase[g]),
      .busy(busy[g]), .done(done[g]), .mem(mif),
      .pe_en(pe_en[g]), .load_psum(load_psum[g]), .shift_in_en(shift_in_en[g]),
      .op_sel(op_sel[g]), .data_n(data_n[g]), .key(key[g])
    );
    assign mif.mem_ready  = ready[g];
    assign mif.mem_rvalid = pv[g][LAT-1] | inj_v[g];
    assign mif.mem_rdata  = inj_v[g] ? inj_d : pd[g][LAT-1];
    assign rd_w[g]        = mif.mem_rd_en;
    assign addr_w[g]      = mif.mem_addr;
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      pv[g] = '0; aidx[g] = 0; rcnt[g] = 0; dcnt[g] = 0; lcnt[g] = 0;
      maxout[g] = 0; stalls[g] = 0; sviol[g] = 0; paddr_q[g] = '0;
      for (int s = 0; s < int'(LAT); s++) pd[g][s] = '0;
    end
    stall_q = '0;
  end

  // Memory model, request log and protocol monitors.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      pv[g][0] <= rd_w[g] & ready[g];
      pd[g][0] <= mem[addr_w[g]];
      for (int s = 1; s < int'(LAT); s++) begin
        pv[g][s] <= pv[g][s-1];
        pd[g][s] <= pd[g][s-1];
      end
      if (rd_w[g] && ready[g]) begin
        alog[g][7'(aidx[g])] <= addr_w[g];
        aidx[g] <= aidx[g] + 1;
      end
      if (pv[g][LAT-1]) rcnt[g] <= rcnt[g] + 1;
      if ((aidx[g] - rcnt[g]) > maxout[g]) maxout[g] <= aidx[g] - rcnt[g];
      if (done[g]) dcnt[g] <= dcnt[g] + 1;
      if (load_psum[g]) lcnt[g] <= lcnt[g] + 1;
      stall_q[g] <= rd_w[g] & ~ready[g];
      paddr_q[g] <= addr_w[g];
      if (rd_w[g] && !ready[g]) stalls[g] <= stalls[g] + 1;
      if (stall_q[g] && (!rd_w[g] || (addr_w[g] != paddr_q[g]))) sviol[g] <= sviol[g] + 1;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_start(input int g, input logic [11:0] sb, input logic [11:0] kb);
    @(negedge clk);
    start[g] = 1'b1; sbase[g] = sb; kbase[g] = kb;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, input string nm);
    int n = 0;
    while (!done[g] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 256'(done[g]), 256'd1);
  endtask

  task automatic chk_addrs(input int g, input int base, input string nm,
                           input logic [11:0] sb, input logic [11:0] kb);
    chk({nm, "_count"}, 256'(aidx[g] - base), 256'd8);
    for (int i = 0; i < 8; i++)
      chk(nm, 256'(alog[g][7'(base + i)]), 256'((i < 4) ? (sb + 12'(i)) : (kb + 12'(i - 4))));
  endtask

  function automatic logic [19:0] ctl(input int g);
    return {busy[g], done[g], rd_w[g], addr_w[g], pe_en[g], load_psum[g], shift_in_en[g], op_sel[g]};
  endfunction

  typedef struct {
    int         cyc;
    logic [6:0] exp;   // {rd_en, done, busy, pe_en, load_psum, op_sel}
  } tv_t;

  tv_t        tv [8];
  logic [6:0] snap [1:16];
  logic [11:0] wrap_exp [8];
  int a0, d0, l0, r0, n;

  initial begin
    tv[0] = '{1,  7'b1_0_1_0_0_00};
    tv[1] = '{8,  7'b1_0_1_0_0_00};
    tv[2] = '{9,  7'b0_0_1_0_0_00};
    tv[3] = '{10, 7'b0_0_1_0_0_00};
    tv[4] = '{11, 7'b0_0_1_1_1_00};
    tv[5] = '{12, 7'b0_0_1_1_0_01};
    tv[6] = '{13, 7'b0_1_1_0_0_00};
    tv[7] = '{14, 7'b0_0_0_0_0_00};
    wrap_exp = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h030, 12'h031, 12'h032, 12'h033};

    for (int i = 0; i < 4096; i++) mem[i] = 32'(i) ^ 32'hA5A50000;
    mem[12'h010] = 32'h44332211; mem[12'h011] = 32'h88776655;
    mem[12'h012] = 32'hCCBBAA99; mem[12'h013] = 32'h00FFEEDD;
    for (int i = 0; i < 4; i++) mem[12'h020 + i] = 32'h01010101;

    rst_n = '0; start = '0; ready = 2'b11; inj_v = '0; inj_d = '0;
    for (int g = 0; g < 2; g++) begin sbase[g] = '0; kbase[g] = '0; end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset_ctl", 256'(ctl(g)), 256'd0);
      chk("reset_bus", {data_n[g], key[g]}, 256'd0);
    end
    rst_n = 2'b11;
    repeat (2) @(negedge clk);
    chk("idle_ctl", 256'(ctl(0)), 256'd0);

    // Basic load on instance 0: cycle-accurate timeline from the accepted start edge.
    a0 = aidx[0]; d0 = dcnt[0];
    start[0] = 1'b1; sbase[0] = 12'h010; kbase[0] = 12'h020;
    @(posedge clk);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      snap[c] = {rd_w[0], done[0], busy[0], pe_en[0], load_psum[0], op_sel[0]};
    end
    for (int i = 0; i < 8; i++) chk($sformatf("timeline_c%0d", tv[i].cyc), 256'(snap[tv[i].cyc]), 256'(tv[i].exp));
    chk_addrs(0, a0, "basic_addr", 12'h010, 12'h020);
    chk("basic_data_n", 256'(data_n[0]), 256'(EXP_DATA));
    chk("basic_key", 256'(key[0]), 256'(EXP_KEY));
    chk("basic_byte0_15", 256'({data_n[0][7:0], data_n[0][127:120]}), 256'(16'h1100));
    chk("basic_ark_s00_s33", 256'({data_n[0][7:0] ^ key[0][7:0], data_n[0][127:120] ^ key[0][127:120]}), 256'(16'h1001));
    chk("basic_done_count", 256'(dcnt[0] - d0), 256'd1);

    // Spurious rvalid in IDLE.
    @(negedge clk);
    inj_v[0] = 1'b1; inj_d = 32'hDEADBEEF;
    @(negedge clk);
    chk("spur_busy", 256'(busy[0]), 256'd0);
    inj_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_bus", {data_n[0], key[0]}, {EXP_DATA, EXP_KEY});
    chk("spur_busy_after", 256'(busy[0]), 256'd0);

    // Second start during FETCH must be ignored.
    a0 = aidx[0]; d0 = dcnt[0];
    run_start(0, 12'h010, 12'h020);
    repeat (2) @(negedge clk);
    start[0] = 1'b1; sbase[0] = 12'h200; kbase[0] = 12'h300;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 40, "busy_done_seen");
    repeat (20) @(negedge clk);
    chk("busy_done_count", 256'(dcnt[0] - d0), 256'd1);
    chk_addrs(0, a0, "busy_addr", 12'h010, 12'h020);
    chk("busy_bus", {data_n[0], key[0]}, {EXP_DATA, EXP_KEY});

    // Address wrap-around.
    a0 = aidx[0];
    run_start(0, 12'hFFE, 12'h030);
    wait_done(0, 40, "wrap_done_seen");
    chk("wrap_count", 256'(aidx[0] - a0), 256'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("wrap_addr%0d", i), 256'(alog[0][7'(a0 + i)]), 256'(wrap_exp[i]));
    repeat (4) @(negedge clk);

    // Reset mid-fetch after three returns, then late returns and a fresh start.
    r0 = rcnt[0]; l0 = lcnt[0];
    run_start(0, 12'h010, 12'h020);
    n = 0;
    while ((rcnt[0] - r0) < 3 && n < 30) begin @(negedge clk); n++; end
    chk("rst_three_returns", 256'((rcnt[0] - r0) >= 3), 256'd1);
    rst_n[0] = 1'b0;
    #1;
    chk("rst_ctl", 256'(ctl(0)), 256'd0);
    chk("rst_bus", {data_n[0], key[0]}, 256'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    inj_v[0] = 1'b1; inj_d = 32'hDEADBEEF;
    @(negedge clk);
    inj_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_late_busy", 256'(busy[0]), 256'd0);
    chk("rst_late_bus", {data_n[0], key[0]}, 256'd0);
    chk("rst_no_load", 256'(lcnt[0] - l0), 256'd0);
    run_start(0, 12'h010, 12'h020);
    wait_done(0, 40, "rst_fresh_done");
    chk("rst_fresh_bus", {data_n[0], key[0]}, {EXP_DATA, EXP_KEY});
    chk("rst_fresh_load", 256'(lcnt[0] - l0), 256'd1);

    // Backpressure on instance 1 (MAX_OUT=2): mem_ready low every other cycle.
    a0 = aidx[1];
    ready[1] = 1'b0;
    run_start(1, 12'h010, 12'h020);
    n = 0;
    while (!done[1] && n < 200) begin
      @(negedge clk);
      ready[1] = ~ready[1];
      n++;
    end
    chk("bp_done_seen", 256'(done[1]), 256'd1);
    ready[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_max_out", 256'(maxout[1] <= 2), 256'd1);
    chk("bp_stalls_seen", 256'(stalls[1] > 0), 256'd1);
    chk("bp_stall_hold", 256'(sviol[1]), 256'd0);
    chk_addrs(1, a0, "bp_addr", 12'h010, 12'h020);
    chk("bp_bus", {data_n[1], key[1]}, {EXP_DATA, EXP_KEY});
    chk("inst0_stall_hold", 256'(sviol[0]), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
